// File: rtl/cordic_iter_ctrl_if.sv
// Handshake and operand/result bundle for cordic_iter_ctrl.
//   start, mode, x_in, y_in, z_in : request side (driven by the master)
//   busy, done, x_out, y_out, z_out : status/result side (driven by the slave)
interface cordic_iter_ctrl_if #(
  parameter int unsigned WIDTH = 18
);
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;

  modport master (
    output start, mode, x_in, y_in, z_in,
    input  busy, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, mode, x_in, y_in, z_in,
    output busy, done, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC engine: one micro-rotation per clock, ITER rotations per
// operation, rotation (z -> 0) or vectoring (y -> 0) mode, no gain correction.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of cordic_iter_ctrl_if (start/mode/operands in,
//                busy/done/saturated results out, all outputs registered)
// Angles are signed WIDTH-bit with 2^(WIDTH-1) = pi rad.
module cordic_iter_ctrl #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned ITER  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cordic_iter_ctrl_if.slave    bus
);

  localparam int unsigned WW = WIDTH + 2;        // work width incl. guard bits
  localparam int unsigned CW = $clog2(ITER);     // iteration counter width

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // atan(2^-i) scaled so that pi = 2^31, rounded to nearest
  localparam logic [31:0] ATAN_T [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // Rescale the 2^31 = pi table to 2^(WIDTH-1) = pi with round-half-up
  function automatic logic signed [WW-1:0] atan_rom(input logic [CW-1:0] idx);
    logic [32:0] t;
    t = {ATAN_T[5'(idx)], 1'b0} + (33'd1 << (32 - WIDTH));
    return WW'(t >> (33 - WIDTH));
  endfunction

  // Clamp a guard-bit work value into the signed WIDTH-bit range
  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WW-1:0] v);
    if ((&v[WW-1:WIDTH-1]) || !(|v[WW-1:WIDTH-1]))
      return v[WIDTH-1:0];
    else if (v[WW-1])
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           i_q, i_d;
  logic                    mode_q, mode_d;
  logic signed [WW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    neg_c;   // micro-rotation direction d = -1
  logic signed [WW-1:0]    x_sh_c, y_sh_c, atan_c;

  assign neg_c  = mode_q ? ~y_q[WW-1] : z_q[WW-1];
  assign x_sh_c = x_q >>> i_q;
  assign y_sh_c = y_q >>> i_q;
  assign atan_c = atan_rom(i_q);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    zo_d    = zo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          mode_d  = bus.mode;
          x_d     = WW'(bus.x_in);
          y_d     = WW'(bus.y_in);
          z_d     = WW'(bus.z_in);
          i_d     = '0;
        end
      end
      S_RUN: begin
        if (neg_c) begin
          x_d = x_q + y_sh_c;
          y_d = y_q - x_sh_c;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh_c;
          y_d = y_q + x_sh_c;
          z_d = z_q - atan_c;
        end
        i_d = i_q + CW'(1);
        if (i_q == CW'(ITER - 1)) begin
          state_d = S_DONE;
          i_d     = '0;
          xo_d    = sat(x_d);
          yo_d    = sat(y_d);
          zo_d    = sat(z_d);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.x_out = xo_q;
  assign bus.y_out = yo_q;
  assign bus.z_out = zo_q;

endmodule
